// File: rtl/pong_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : pong_scoreboard
// Purpose  : Edge-qualified BCD match scoring with win detection and freeze.
//            Optional win-by-two rule: define SCOREBOARD_WIN_BY_TWO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pong_scoreboard #(
    parameter int WIN_SCORE = 5
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       count_en,
    input  logic       p1_point,
    input  logic       p2_point,
    output logic [3:0] p1_ones,
    output logic [3:0] p1_tens,
    output logic [3:0] p2_ones,
    output logic [3:0] p2_tens,
    output logic       point_pulse,
    output logic       game_over,
    output logic [1:0] winner
);

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        LOCKOUT = 2'd1,
        OVER    = 2'd2
    } state_t;

    // Packed BCD orders numerically, so plain unsigned compares are valid.
    localparam logic [7:0] WIN_BCD = {4'(WIN_SCORE / 10), 4'(WIN_SCORE % 10)};

    state_t     state_q, state_d;
    logic [7:0] p1_score_q, p1_score_d;
    logic [7:0] p2_score_q, p2_score_d;
    logic       p1_prev_q, p1_prev_d;
    logic       p2_prev_q, p2_prev_d;
    logic       point_pulse_q, point_pulse_d;
    logic       game_over_q, game_over_d;
    logic [1:0] winner_q, winner_d;

    logic       p1_rise, p2_rise;
    logic [7:0] scorer_old, scorer_new, opp_score;
    logic       win;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99)
            return v;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

`ifdef SCOREBOARD_WIN_BY_TWO_EN
    // Returns {overflow, v+2}; overflow means v+2 exceeds 99.
    function automatic logic [8:0] bcd_add2(input logic [7:0] v);
        logic [3:0] ones;
        logic [3:0] tens;
        logic       carry;
        carry = (v[3:0] >= 4'd8);
        ones  = carry ? (v[3:0] - 4'd8) : (v[3:0] + 4'd2);
        tens  = v[7:4] + {3'd0, carry};
        if (carry && v[7:4] == 4'd9)
            return {1'b1, 8'h00};
        else
            return {1'b0, tens, ones};
    endfunction

    logic [8:0] opp_plus2;
    assign opp_plus2 = bcd_add2(opp_score);
    assign win = (scorer_old == 8'h99) ||
                 ((scorer_new >= WIN_BCD) && !opp_plus2[8] && (scorer_new >= opp_plus2[7:0]));
`else
    assign win = (scorer_new == WIN_BCD);
`endif

    assign p1_rise    = p1_point & ~p1_prev_q;
    assign p2_rise    = p2_point & ~p2_prev_q;
    assign scorer_old = p1_rise ? p1_score_q : p2_score_q;
    assign opp_score  = p1_rise ? p2_score_q : p1_score_q;
    assign scorer_new = bcd_inc(scorer_old);

    always_comb begin
        state_d       = state_q;
        p1_score_d    = p1_score_q;
        p2_score_d    = p2_score_q;
        p1_prev_d     = p1_point;
        p2_prev_d     = p2_point;
        point_pulse_d = 1'b0;
        game_over_d   = game_over_q;
        winner_d      = winner_q;

        if (clear) begin
            state_d     = ARMED;
            p1_score_d  = 8'h00;
            p2_score_d  = 8'h00;
            game_over_d = 1'b0;
            winner_d    = 2'b00;
        end else begin
            case (state_q)
                ARMED: begin
                    // A tie of rises scores nothing.
                    if (count_en && (p1_rise ^ p2_rise)) begin
                        point_pulse_d = 1'b1;
                        if (p1_rise)
                            p1_score_d = scorer_new;
                        else
                            p2_score_d = scorer_new;
                        if (win) begin
                            state_d     = OVER;
                            game_over_d = 1'b1;
                            winner_d    = p1_rise ? 2'b01 : 2'b10;
                        end else begin
                            state_d = LOCKOUT;
                        end
                    end
                end
                LOCKOUT: begin
                    if (!p1_point && !p2_point)
                        state_d = ARMED;
                end
                OVER: begin
                    state_d = OVER;
                end
                default: begin
                    state_d = ARMED;
                end
            endcase
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ARMED;
            p1_score_q    <= 8'h00;
            p2_score_q    <= 8'h00;
            p1_prev_q     <= 1'b0;
            p2_prev_q     <= 1'b0;
            point_pulse_q <= 1'b0;
            game_over_q   <= 1'b0;
            winner_q      <= 2'b00;
        end else begin
            state_q       <= state_d;
            p1_score_q    <= p1_score_d;
            p2_score_q    <= p2_score_d;
            p1_prev_q     <= p1_prev_d;
            p2_prev_q     <= p2_prev_d;
            point_pulse_q <= point_pulse_d;
            game_over_q   <= game_over_d;
            winner_q      <= winner_d;
        end
    end

    assign p1_tens     = p1_score_q[7:4];
    assign p1_ones     = p1_score_q[3:0];
    assign p2_tens     = p2_score_q[7:4];
    assign p2_ones     = p2_score_q[3:0];
    assign point_pulse = point_pulse_q;
    assign game_over   = game_over_q;
    assign winner      = winner_q;

endmodule
`default_nettype wire

// File: tb/tb_pong_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_pong_scoreboard
// Purpose  : Directed scoreboard bench for pong_scoreboard (WIN_SCORE = 12).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pong_scoreboard;

    logic       clk_100MHz = 1'b0;
    logic       reset_n    = 1'b0;
    logic       clear      = 1'b0;
    logic       count_en   = 1'b0;
    logic       p1_point   = 1'b0;
    logic       p2_point   = 1'b0;
    logic [3:0] p1_ones, p1_tens, p2_ones, p2_tens;
    logic       point_pulse, game_over;
    logic [1:0] winner;

    int checks      = 0;
    int failures    = 0;
    int pulses      = 0;
    int exp_pulses  = 0;
    bit prev_pulse  = 1'b0;
    logic [17:0] exp_q[$];

    pong_scoreboard #(.WIN_SCORE(12)) dut (
        .clk_100MHz (clk_100MHz),
        .reset_n    (reset_n),
        .clear      (clear),
        .count_en   (count_en),
        .p1_point   (p1_point),
        .p2_point   (p2_point),
        .p1_ones    (p1_ones),
        .p1_tens    (p1_tens),
        .p2_ones    (p2_ones),
        .p2_tens    (p2_tens),
        .point_pulse(point_pulse),
        .game_over  (game_over),
        .winner     (winner)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    // {p1_tens, p1_ones, p2_tens, p2_ones, game_over, winner}
    function automatic logic [17:0] pack(input int p1, input int p2, input bit go, input logic [1:0] w);
        return {4'(p1 / 10), 4'(p1 % 10), 4'(p2 / 10), 4'(p2 % 10), go, w};
    endfunction

    function automatic logic [17:0] snap();
        return {p1_tens, p1_ones, p2_tens, p2_ones, game_over, winner};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every strobe must match the oldest expected point.
    always @(negedge clk_100MHz) begin
        if (reset_n && point_pulse) begin
            pulses++;
            checks++;
            if (prev_pulse) begin
                failures++;
                $display("FAIL pulse_width actual=2+ required=1");
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse actual=%0h required=none", snap());
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                if (snap() !== e) begin
                    failures++;
                    $display("FAIL point_state actual=%0h required=%0h", snap(), e);
                end
            end
        end
        prev_pulse = reset_n && point_pulse;
    end

    task automatic score(input int who, input bit accept, input logic [17:0] e);
        @(negedge clk_100MHz);
        if (who == 1) p1_point = 1'b1; else p2_point = 1'b1;
        if (accept) begin
            exp_q.push_back(e);
            exp_pulses++;
        end
        repeat (2) @(negedge clk_100MHz);
        p1_point = 1'b0;
        p2_point = 1'b0;
        repeat (2) @(negedge clk_100MHz);
    endtask

    task automatic do_clear();
        @(negedge clk_100MHz);
        clear = 1'b1;
        @(negedge clk_100MHz);
        clear = 1'b0;
        chk("clear_zero", 32'(snap()), 32'(pack(0, 0, 1'b0, 2'b00)));
    endtask

    initial begin
        repeat (3) @(negedge clk_100MHz);
        chk("reset_state", 32'({snap(), point_pulse}), 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_100MHz);

        // First point and long hold
        count_en = 1'b1;
        @(negedge clk_100MHz);
        p1_point = 1'b1;
        exp_q.push_back(pack(1, 0, 1'b0, 2'b00));
        exp_pulses++;
        repeat (1000) @(negedge clk_100MHz);
        chk("hold_p1_ones", 32'(p1_ones), 32'd1);
        chk("hold_pulses", 32'(pulses), 32'd1);
        p1_point = 1'b0;
        repeat (2) @(negedge clk_100MHz);

        // Tie
        p1_point = 1'b1;
        p2_point = 1'b1;
        repeat (3) @(negedge clk_100MHz);
        p1_point = 1'b0;
        p2_point = 1'b0;
        repeat (2) @(negedge clk_100MHz);
        chk("tie_scores", 32'(snap()), 32'(pack(1, 0, 1'b0, 2'b00)));
        chk("tie_pulses", 32'(pulses), 32'd1);

        // Rise while disabled, then enabled while held
        count_en = 1'b0;
        p2_point = 1'b1;
        repeat (2) @(negedge clk_100MHz);
        count_en = 1'b1;
        repeat (5) @(negedge clk_100MHz);
        chk("held_no_point", 32'(p2_ones), 32'd0);
        p2_point = 1'b0;
        repeat (2) @(negedge clk_100MHz);
        score(2, 1'b1, pack(1, 1, 1'b0, 2'b00));
        chk("p2_after_refall", 32'(p2_ones), 32'd1);

        // Run player 1 to the win
        do_clear();
        for (int i = 1; i <= 12; i++)
            score(1, 1'b1, pack(i, 0, i == 12, (i == 12) ? 2'b01 : 2'b00));
        chk("p1_win_state", 32'(snap()), 32'(pack(12, 0, 1'b1, 2'b01)));
        score(2, 1'b0, 18'h0);
        chk("over_frozen", 32'(snap()), 32'(pack(12, 0, 1'b1, 2'b01)));
        chk("over_pulses", 32'(pulses), 32'(exp_pulses));
        do_clear();

        // Clear and rise in the same cycle
        @(negedge clk_100MHz);
        clear    = 1'b1;
        p1_point = 1'b1;
        @(negedge clk_100MHz);
        clear = 1'b0;
        chk("clear_beats_rise", 32'({snap(), point_pulse}), 32'h0);
        repeat (2) @(negedge clk_100MHz);
        p1_point = 1'b0;
        repeat (2) @(negedge clk_100MHz);
        chk("clear_rise_pulses", 32'(pulses), 32'(exp_pulses));

        // Close game at 11-11
        for (int i = 1; i <= 11; i++)
            score(1, 1'b1, pack(i, 0, 1'b0, 2'b00));
        for (int i = 1; i <= 11; i++)
            score(2, 1'b1, pack(11, i, 1'b0, 2'b00));
`ifdef SCOREBOARD_WIN_BY_TWO_EN
        score(2, 1'b1, pack(11, 12, 1'b0, 2'b00));
        score(1, 1'b1, pack(12, 12, 1'b0, 2'b00));
        score(1, 1'b1, pack(13, 12, 1'b0, 2'b00));
        score(1, 1'b1, pack(14, 12, 1'b1, 2'b01));
        chk("win_by_two_final", 32'(snap()), 32'(pack(14, 12, 1'b1, 2'b01)));
`else
        score(2, 1'b1, pack(11, 12, 1'b1, 2'b10));
        chk("p2_win_final", 32'(snap()), 32'(pack(11, 12, 1'b1, 2'b10)));
`endif

        // Asynchronous reset mid-match
        do_clear();
        score(1, 1'b1, pack(1, 0, 1'b0, 2'b00));
        @(negedge clk_100MHz);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_reset", 32'({snap(), point_pulse}), 32'h0);
        @(negedge clk_100MHz);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_100MHz);
        chk("post_reset_state", 32'(snap()), 32'h0);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("total_pulses", 32'(pulses), 32'(exp_pulses));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
